gray_count_monitor: RTL and testbench
=====================================

Name: gray_count_monitor

Overview:
- Receive side of the GrayCounter gray-code output.
- Samples a free-running gray-coded count (typically a remote GrayCounter readGray bus) through a synchronizer chain and decodes it to binary.
- Classifies each change as up-step, down-step or illegal multi-bit jump, and accumulates a signed net delta that a client drains through an atomicc-style method.
- Used by FIFO pointer comparison and trace-rate logic that consume GrayCounter values.

Parameters:
- width, 10: gray/binary count width (≥2).
- SYNC_STAGES, 2: synchronizer flops on grayIn (2..4).
- ACC_WIDTH, 16: signed net-delta accumulator width.
- ERR_WIDTH, 8: illegal-transition counter width.

Ports:
- CLK  in  1  clock; all state on rising edge.
- nRST  in  1  synchronous active-high reset; 1 = reset, sampled on CLK.
- grayIn  in  width  gray-coded count from the producer.
- readBin  out  width  decoded binary count.
- readBin__RDY  out  1  readBin valid (warm-up complete).
- readDelta  out  ACC_WIDTH  signed net steps since last drain.
- readDelta__RDY  out  1  = readBin__RDY.
- drainDelta__ENA  in  1  take readDelta and clear accumulator.
- drainDelta__RDY  out  1  = readBin__RDY.
- error  out  1  sticky illegal-transition flag.
- errorCount  out  ERR_WIDTH  saturating illegal-transition count.
- clearError__ENA  in  1  clear error and errorCount.
- clearError__RDY  out  1  constant 1.

Behaviour:
- Reset (nRST=1 at edge): sync chain, prevGray, readBin, accumulator, error, errorCount and warm-up counter all = 0; every __RDY except clearError__RDY = 0. Reset mid-operation discards all state on that edge.
- Sync: grayIn passes through SYNC_STAGES flops; sg = last flop.
- Warm-up: counter counts SYNC_STAGES+1 edges after reset release. On the final warm-up edge: prevGray <= sg, readBin <= gray2bin(sg), RDY outputs rise next cycle. No classification during warm-up.
- After warm-up, each cycle evaluate d = popcount(sg ^ prevGray):
  - d=0: no change.
  - d=1: legal step. newBin = gray2bin(sg). Up if newBin == readBin+1 mod 2^width; otherwise down (readBin-1 mod 2^width). Wrap max->0 is up; 0->max is down.
  - d>1: illegal. error <= 1; errorCount +1, saturating at all-ones; accumulator unchanged.
  - In every case prevGray <= sg and readBin <= gray2bin(sg).
- Latency: a grayIn change reaches readBin SYNC_STAGES+1 cycles later. The accumulator updates on the same edge as readBin.
- gray2bin: b[width-1] = g[width-1]; b[i] = b[i+1] ^ g[i]. Combinational from sg, registered into readBin.
- Accumulator: signed; +1 on up, -1 on down. Saturates at +2^(ACC_WIDTH-1)-1 and -2^(ACC_WIDTH-1); never wraps.
- readDelta = accumulator register (combinational output).
- drainDelta__ENA (legal only when RDY): accumulator <= step of this cycle (+1, -1 or 0). The returned value excludes that step, so no steps are lost.
- clearError__ENA:
  - error <= 0, errorCount <= 0.
  - If an illegal transition occurs in the same cycle: error <= 1, errorCount <= 1.
- ENA asserted while RDY=0 is ignored.

Decomposition:
- Shared package gray_pkg:
  - function gray2bin and bin2gray, parameterized by width.
  - typedef step_e {STEP_NONE, STEP_UP, STEP_DOWN, STEP_ILLEGAL}.
  - constant SYNC_STAGES_MIN = 2.
- One sub-module, gray_sync_chain (width, SYNC_STAGES): a plain flop chain, reused by future async FIFOs.
- Classifier, accumulator and error logic stay in gray_count_monitor.

Test Plan:
- width=4, SYNC_STAGES=2. Reset, hold grayIn=0 -> RDY rises 4 cycles after reset release; readBin=0, readDelta=0.
- Drive grayIn 0000,0001,0011,0010 one per cycle -> readBin 0,1,2,3 with 3-cycle lag; readDelta=+3; error=0.
- Wrap: from bin 15 (gray 1000) drive 0000 -> readDelta +1. Then drive 1000 -> readDelta back to 0, classified down.
- Illegal: from gray 0000 jump to 0011 -> error=1, errorCount=1, readDelta unchanged, readBin=2. Assert clearError__ENA alone -> error=0, errorCount=0.
- Drain collision: readDelta=+5 and an up-step lands on the drain edge -> drained value 5, readDelta=+1 next cycle.
- Saturation: ACC_WIDTH=4, 10 consecutive up-steps -> readDelta holds +7. Assert nRST mid-sequence -> all outputs 0 next cycle, RDY low for 3 cycles after release.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared gray-code helpers and step classification for GrayCounter consumers.
// The conversions work on values of any width up to 32 bits when zero-extended.
package gray_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int GRAY_MAX_W      = 32;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_UP,
    STEP_DOWN,
    STEP_ILLEGAL
  } step_e;

  // With the unused upper bits zero, the prefix XOR from the top is
  // identical for every width, so one implementation serves all widths.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_sync_chain.sv
// Plain multi-flop synchronizer for a gray-coded bus; only one bit changes
// per producer step, so each bit may be synchronized independently.
module gray_sync_chain #(
  parameter int width       = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  logic [width-1:0] stage [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/gray_count_monitor.sv
// Receive side of a GrayCounter: synchronizes and decodes the gray count,
// classifies each change and accumulates a drainable signed net delta.
module gray_count_monitor
  import gray_pkg::*;
#(
  parameter int width       = 10,
  parameter int SYNC_STAGES = 2,
  parameter int ACC_WIDTH   = 16,
  parameter int ERR_WIDTH   = 8
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [width-1:0]     grayIn,
  output logic [width-1:0]     readBin,
  output logic                 readBin__RDY,
  output logic [ACC_WIDTH-1:0] readDelta,
  output logic                 readDelta__RDY,
  input  logic                 drainDelta__ENA,
  output logic                 drainDelta__RDY,
  output logic                 error,
  output logic [ERR_WIDTH-1:0] errorCount,
  input  logic                 clearError__ENA,
  output logic                 clearError__RDY
);

  localparam int WARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [WARM_W-1:0]           WARM_ONE  = WARM_W'(1);
  localparam logic [WARM_W-1:0]           WARM_LAST = WARM_W'(SYNC_STAGES);
  localparam logic [width-1:0]            BIN_ONE   = width'(1);
  localparam logic [ERR_WIDTH-1:0]        ERR_ONE   = ERR_WIDTH'(1);
  localparam logic signed [ACC_WIDTH-1:0] ACC_ONE   = ACC_WIDTH'(1);
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX   = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN   = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [width-1:0]            sg;
  logic [width-1:0]            prev_gray;
  logic [width-1:0]            read_bin;
  logic [width-1:0]            new_bin;
  logic signed [ACC_WIDTH-1:0] acc;
  logic                        err;
  logic [ERR_WIDTH-1:0]        err_cnt;
  logic [WARM_W-1:0]           warm_cnt;
  logic                        rdy;
  int                          flips;
  step_e                       step;

  function automatic logic signed [ACC_WIDTH-1:0] acc_add(
    input logic signed [ACC_WIDTH-1:0] a, input step_e s);
    case (s)
      STEP_UP:   return (a == ACC_MAX) ? a : a + ACC_ONE;
      STEP_DOWN: return (a == ACC_MIN) ? a : a - ACC_ONE;
      default:   return a;
    endcase
  endfunction

  // Value left in the accumulator after a drain: the step of the drain cycle.
  function automatic logic signed [ACC_WIDTH-1:0] step_val(input step_e s);
    case (s)
      STEP_UP:   return ACC_ONE;
      STEP_DOWN: return -ACC_ONE;
      default:   return '0;
    endcase
  endfunction

  function automatic logic [ERR_WIDTH-1:0] err_inc(input logic [ERR_WIDTH-1:0] c);
    return (c == '1) ? c : c + ERR_ONE;
  endfunction

  gray_sync_chain #(
    .width       (width),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (CLK),
    .rst (nRST),
    .d   (grayIn),
    .q   (sg)
  );

  // Decode and classification of the synchronized sample.
  always_comb begin
    new_bin = width'(gray2bin(32'(sg)));
    flips   = $countones(sg ^ prev_gray);
    step    = STEP_NONE;
    if (rdy) begin
      if (flips == 1) begin
        step = (new_bin == read_bin + BIN_ONE) ? STEP_UP : STEP_DOWN;
      end else if (flips > 1) begin
        step = STEP_ILLEGAL;
      end
    end
  end

  // Registered state: warm-up, decoded count, accumulator, error tracking.
  always_ff @(posedge CLK) begin
    if (nRST) begin
      prev_gray <= '0;
      read_bin  <= '0;
      acc       <= '0;
      err       <= 1'b0;
      err_cnt   <= '0;
      warm_cnt  <= '0;
      rdy       <= 1'b0;
    end else begin
      if (!rdy) begin
        warm_cnt <= warm_cnt + WARM_ONE;
        if (warm_cnt == WARM_LAST) begin
          rdy       <= 1'b1;
          prev_gray <= sg;
          read_bin  <= new_bin;
        end
      end else begin
        prev_gray <= sg;
        read_bin  <= new_bin;
        acc       <= drainDelta__ENA ? step_val(step) : acc_add(acc, step);
      end

      if (step == STEP_ILLEGAL) begin
        err     <= 1'b1;
        err_cnt <= clearError__ENA ? ERR_ONE : err_inc(err_cnt);
      end else if (clearError__ENA) begin
        err     <= 1'b0;
        err_cnt <= '0;
      end
    end
  end

  assign readBin         = read_bin;
  assign readDelta       = acc;
  assign error           = err;
  assign errorCount      = err_cnt;
  assign readBin__RDY    = rdy;
  assign readDelta__RDY  = rdy;
  assign drainDelta__RDY = rdy;
  assign clearError__RDY = 1'b1;

endmodule

// File: tb/tb_gray_count_monitor.sv
// Directed and randomized checks of gray_count_monitor (width 4, 2 sync
// stages, 4-bit accumulator, 3-bit error counter) against a behavioural model.
module tb_gray_count_monitor;

  localparam int W    = 4;
  localparam int SYNC = 2;
  localparam int AW   = 4;
  localparam int EW   = 3;
  localparam int BMAX = (1 << W) - 1;
  localparam int AMAX = (1 << (AW - 1)) - 1;
  localparam int AMIN = -(1 << (AW - 1));
  localparam int EMAX = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic [W-1:0]  gray_i = '0;
  logic          drain_i = 1'b0;
  logic          clr_i = 1'b0;
  logic [W-1:0]  readBin;
  logic          readBin__RDY;
  logic [AW-1:0] readDelta;
  logic          readDelta__RDY;
  logic          drainDelta__RDY;
  logic          error;
  logic [EW-1:0] errorCount;
  logic          clearError__RDY;

  int tests = 0;
  int fails = 0;

  // Behavioural model state
  int m_bin, m_prev, m_acc, m_err, m_cnt, m_warm;
  bit m_rdy;
  int sq[$];

  gray_count_monitor #(
    .width       (W),
    .SYNC_STAGES (SYNC),
    .ACC_WIDTH   (AW),
    .ERR_WIDTH   (EW)
  ) dut (
    .CLK             (clk),
    .nRST            (rst_i),
    .grayIn          (gray_i),
    .readBin         (readBin),
    .readBin__RDY    (readBin__RDY),
    .readDelta       (readDelta),
    .readDelta__RDY  (readDelta__RDY),
    .drainDelta__ENA (drain_i),
    .drainDelta__RDY (drainDelta__RDY),
    .error           (error),
    .errorCount      (errorCount),
    .clearError__ENA (clr_i),
    .clearError__RDY (clearError__RDY)
  );

  always #5 clk = ~clk;

  function automatic int b2g(input int b);
    return b ^ (b >> 1);
  endfunction

  // Inverse by search: the binary value whose gray code matches.
  function automatic int g2b(input int g);
    for (int b = 0; b <= BMAX; b++) begin
      if (b2g(b) == g) return b;
    end
    return -1;
  endfunction

  function automatic int popcnt(input int x);
    int n = 0;
    for (int i = 0; i < W; i++) n += (x >> i) & 1;
    return n;
  endfunction

  task automatic model_reset();
    m_bin = 0; m_prev = 0; m_acc = 0; m_err = 0; m_cnt = 0; m_warm = 0;
    m_rdy = 1'b0;
    sq.delete();
    for (int i = 0; i < SYNC; i++) sq.push_back(0);
  endtask

  task automatic model_edge();
    int sg, nb, diff, st;
    bit ill;
    if (rst_i) begin
      model_reset();
      return;
    end
    sg = sq.pop_front();
    sq.push_back(int'(gray_i));
    st = 0;
    ill = 1'b0;
    if (!m_rdy) begin
      m_warm++;
      if (m_warm == SYNC + 1) begin
        m_rdy  = 1'b1;
        m_bin  = g2b(sg);
        m_prev = sg;
      end
    end else begin
      nb = g2b(sg);
      if (popcnt(sg ^ m_prev) == 1) begin
        diff = (nb - m_bin) & BMAX;
        st = (diff == 1) ? 1 : -1;
      end else if (popcnt(sg ^ m_prev) > 1) begin
        ill = 1'b1;
      end
      if (drain_i) m_acc = st;
      else begin
        m_acc = m_acc + st;
        if (m_acc > AMAX) m_acc = AMAX;
        if (m_acc < AMIN) m_acc = AMIN;
      end
      m_bin  = nb;
      m_prev = sg;
    end
    if (ill) begin
      m_err = 1;
      m_cnt = clr_i ? 1 : ((m_cnt < EMAX) ? m_cnt + 1 : EMAX);
    end else if (clr_i) begin
      m_err = 0;
      m_cnt = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("readBin",         32'(readBin),         32'(m_bin));
    chk("readBin__RDY",    32'(readBin__RDY),    32'(m_rdy));
    chk("readDelta__RDY",  32'(readDelta__RDY),  32'(m_rdy));
    chk("drainDelta__RDY", 32'(drainDelta__RDY), 32'(m_rdy));
    chk("readDelta",       32'(readDelta),       32'(m_acc & ((1 << AW) - 1)));
    chk("error",           32'(error),           32'(m_err));
    chk("errorCount",      32'(errorCount),      32'(m_cnt));
    chk("clearError__RDY", 32'(clearError__RDY), 32'd1);
  endtask

  task automatic cyc(input int g, input bit drn, input bit clr, input bit r);
    gray_i  = W'(g);
    drain_i = drn;
    clr_i   = clr;
    rst_i   = r;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Drive one binary value as gray, then hold it until its step is seen.
  task automatic step_to(input int b, input bit clr);
    cyc(b2g(b), 1'b0, clr, 1'b0);
    repeat (SYNC) cyc(b2g(b), 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int cur;
    model_reset();

    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("reset_rdy", 32'(readBin__RDY), 32'd0);

    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("warm_rdy_low", 32'(readBin__RDY), 32'd0);
    cyc(0, 0, 0, 0);
    chk("warm_rdy_high", 32'(readBin__RDY), 32'd1);
    chk("warm_delta", 32'(readDelta), 32'd0);

    cyc(4'b0001, 0, 0, 0);
    cyc(4'b0011, 0, 0, 0);
    cyc(4'b0010, 0, 0, 0);
    chk("lag_bin1", 32'(readBin), 32'd1);
    cyc(4'b0010, 0, 0, 0);
    cyc(4'b0010, 0, 0, 0);
    chk("up3_bin", 32'(readBin), 32'd3);
    chk("up3_delta", 32'(readDelta), 32'd3);

    for (int b = 4; b <= BMAX; b++) cyc(b2g(b), 0, 0, 0);
    repeat (SYNC) cyc(b2g(BMAX), 0, 0, 0);
    chk("sat_delta", 32'(readDelta), 32'd7);
    cyc(b2g(BMAX), 1, 0, 0);
    chk("drain_idle", 32'(readDelta), 32'd0);

    step_to(0, 0);
    chk("wrap_up", 32'(readDelta), 32'd1);
    step_to(BMAX, 0);
    chk("wrap_down", 32'(readDelta), 32'd0);

    step_to(0, 0);
    cyc(4'b0011, 0, 0, 0);
    repeat (SYNC) cyc(4'b0011, 0, 0, 0);
    chk("ill_err", 32'(error), 32'd1);
    chk("ill_cnt", 32'(errorCount), 32'd1);
    chk("ill_delta", 32'(readDelta), 32'd1);
    chk("ill_bin", 32'(readBin), 32'd2);
    cyc(4'b0011, 0, 1, 0);
    chk("clr_err", 32'(error), 32'd0);
    chk("clr_cnt", 32'(errorCount), 32'd0);

    cyc(4'b0011, 1, 0, 0);
    for (int b = 3; b <= 8; b++) cyc(b2g(b), 0, 0, 0);
    cyc(b2g(8), 0, 0, 0);
    chk("pre_drain", 32'(readDelta), 32'd5);
    cyc(b2g(8), 1, 0, 0);
    chk("drain_collide", 32'(readDelta), 32'd1);

    for (int i = 0; i < 12; i++) cyc((i % 2 == 0) ? 4'b0000 : 4'b0011, 0, 0, 0);
    repeat (SYNC) cyc(4'b0011, 0, 0, 0);
    chk("errcnt_sat", 32'(errorCount), 32'd7);

    cyc(4'b0011, 0, 0, 1);
    chk("midrst_bin", 32'(readBin), 32'd0);
    chk("midrst_err", 32'(errorCount), 32'd0);
    cyc(4'b0011, 0, 0, 0);
    cyc(4'b0011, 0, 0, 0);
    chk("midrst_rdy_low", 32'(readBin__RDY), 32'd0);
    cyc(4'b0011, 0, 0, 0);
    chk("midrst_bin_load", 32'(readBin), 32'd2);

    cur = 2;
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 40)      cur = (cur + 1) & BMAX;
      else if (r < 70) cur = (cur - 1) & BMAX;
      else if (r < 92) cur = cur;
      else             cur = int'($urandom_range(0, BMAX));
      cyc(b2g(cur), ($urandom_range(0, 7) == 0), ($urandom_range(0, 14) == 0),
          ($urandom_range(0, 149) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
